// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: D-stage stall/bubble control from Tuse/Tnew hazards and mult/div busy tracking.
// Define HAZARD_STALL_CNT_EN to enable the stall_cycles performance counter.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_md_use,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs, stall_rt, data_stall;
  assign stall_rs   = (D_rs != '0) & ((D_rs == E_wa & D_tuse_rs < E_tnew) | (D_rs == M_wa & D_tuse_rs < M_tnew));
  assign stall_rt   = (D_rt != '0) & ((D_rt == E_wa & D_tuse_rt < E_tnew) | (D_rt == M_wa & D_tuse_rt < M_tnew));
  assign data_stall = stall_rs | stall_rt;
  assign md_busy    = E_md_start | (cnt_q != '0);
  assign stall      = data_stall | (D_md_use & md_busy);
  // A start always reloads, even in BUSY; otherwise count down to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (E_md_start) begin
      cnt_d   = E_md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      state_d = BUSY;
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table vectors, multi-cycle sequences and random stimulus against a cycle-count model.
module tb_hazard_stall_ctrl;
  localparam int ML = 5, DL = 10;
  logic clk = 1'b0, rst;
  logic [4:0] D_rs, D_rt, E_wa, M_wa;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic D_md_use, E_md_start, E_md_is_div, stall, md_busy;
  logic [31:0] stall_cycles;
  int checks = 0, failures = 0;
  int cyc_n = 0, busy_end = -1;
  logic [31:0] sc_m = 0;
  logic s_stall, s_busy;
  logic [31:0] s_sc;
  typedef struct {
    logic [4:0] rs, rt, ewa, mwa;
    logic [1:0] trs, trt, etnew, mtnew;
    logic exp;
  } vec_t;
  vec_t vecs[9];
  hazard_stall_ctrl dut (
    .clk(clk), .rst(rst), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_md_use(D_md_use), .E_wa(E_wa), .E_tnew(E_tnew), .M_wa(M_wa), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .stall(stall), .md_busy(md_busy),
    .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Remaining wait in cycles for a source operand: producer's ready time minus when D needs it.
  function automatic logic must_wait(input logic [4:0] r, input logic [1:0] tu);
    int we, wm;
    we = (r != 0 && r == E_wa) ? int'(E_tnew) - int'(tu) : 0;
    wm = (r != 0 && r == M_wa) ? int'(M_tnew) - int'(tu) : 0;
    return we > 0 || wm > 0;
  endfunction
  task automatic tick(input string nm);
    logic eb, es;
    #1;
    eb = E_md_start || cyc_n <= busy_end;
    es = must_wait(D_rs, D_tuse_rs) || must_wait(D_rt, D_tuse_rt) || (D_md_use && eb);
    s_stall = stall; s_busy = md_busy; s_sc = stall_cycles;
    chk({nm, " stall"}, {31'd0, stall}, {31'd0, es});
    chk({nm, " md_busy"}, {31'd0, md_busy}, {31'd0, eb});
`ifdef HAZARD_STALL_CNT_EN
    chk({nm, " stall_cycles"}, stall_cycles, sc_m);
`else
    chk({nm, " stall_cycles"}, stall_cycles, 32'h0);
`endif
    if (rst) begin
      busy_end = -1;
      sc_m = 0;
    end else begin
      if (E_md_start) busy_end = cyc_n + (E_md_is_div ? DL : ML);
      if (es) sc_m = sc_m + 1;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet();
    D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3; D_md_use = 0;
    E_wa = 0; E_tnew = 0; M_wa = 0; M_tnew = 0; E_md_start = 0; E_md_is_div = 0; rst = 0;
  endtask
  task automatic load_use();
    E_wa = 8; E_tnew = 2; D_rs = 8; D_tuse_rs = 1; M_wa = 0;
  endtask
  initial begin
    int n;
    vecs[0] = '{rs:8, rt:0, trs:1, trt:3, ewa:8, etnew:2, mwa:0, mtnew:0, exp:1};
    vecs[1] = '{rs:8, rt:0, trs:1, trt:3, ewa:0, etnew:0, mwa:8, mtnew:1, exp:0};
    vecs[2] = '{rs:0, rt:0, trs:0, trt:0, ewa:0, etnew:2, mwa:0, mtnew:0, exp:0};
    vecs[3] = '{rs:8, rt:0, trs:3, trt:3, ewa:8, etnew:2, mwa:8, mtnew:2, exp:0};
    vecs[4] = '{rs:0, rt:9, trs:3, trt:0, ewa:9, etnew:1, mwa:0, mtnew:0, exp:1};
    vecs[5] = '{rs:0, rt:9, trs:3, trt:0, ewa:5, etnew:2, mwa:9, mtnew:1, exp:1};
    vecs[6] = '{rs:0, rt:9, trs:3, trt:1, ewa:5, etnew:2, mwa:9, mtnew:1, exp:0};
    vecs[7] = '{rs:4, rt:4, trs:2, trt:2, ewa:4, etnew:2, mwa:0, mtnew:0, exp:0};
    vecs[8] = '{rs:4, rt:7, trs:0, trt:1, ewa:4, etnew:0, mwa:7, mtnew:2, exp:1};
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    tick("reset");
    chk("reset md_busy", {31'd0, s_busy}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      D_rs = vecs[i].rs; D_rt = vecs[i].rt; D_tuse_rs = vecs[i].trs; D_tuse_rt = vecs[i].trt;
      E_wa = vecs[i].ewa; E_tnew = vecs[i].etnew; M_wa = vecs[i].mwa; M_tnew = vecs[i].mtnew;
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), {31'd0, s_stall}, {31'd0, vecs[i].exp});
    end
    quiet();
    load_use();
    tick("load_use");
    chk("load_use stall", {31'd0, s_stall}, 32'd1);
    E_wa = 0; M_wa = 8; M_tnew = 1;
    tick("load_use_next");
    chk("load_use_next stall", {31'd0, s_stall}, 32'd0);
    quiet();
    D_md_use = 1; E_md_start = 1; E_wa = 6; E_tnew = 2; D_rs = 6; D_tuse_rs = 0;
    tick("both_stall");
    chk("both_stall stall", {31'd0, s_stall}, 32'd1);
    E_md_start = 0; E_wa = 0;
    for (int i = 0; i < 6; i++) tick("drain");
    quiet();
    D_md_use = 1; E_md_start = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick("mult");
      E_md_start = 0;
      n += int'(s_stall);
    end
    chk("mult stall count", n, 6);
    quiet();
    E_md_start = 1; E_md_is_div = 1;
    tick("div");
    E_md_start = 0;
    repeat (3) tick("div_busy");
    rst = 1;
    tick("div_rst");
    rst = 0;
    tick("after_rst");
    chk("after_rst md_busy", {31'd0, s_busy}, 32'd0);
    rst = 1; E_md_start = 1;
    tick("start_in_rst");
    rst = 0; E_md_start = 0;
    tick("start_in_rst_next");
    chk("start_in_rst md_busy", {31'd0, s_busy}, 32'd0);
    E_md_start = 1; E_md_is_div = 1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      tick("div_fresh");
      E_md_start = 0;
      n += int'(s_busy);
    end
    chk("div busy count", n, 11);
    quiet();
    E_md_start = 1;
    tick("reload_mult");
    E_md_start = 0;
    repeat (2) tick("reload_wait");
    E_md_start = 1; E_md_is_div = 1;
    n = 0;
    for (int i = 0; i < 13; i++) begin
      tick("reload_div");
      E_md_start = 0;
      n += int'(s_busy);
    end
    chk("reload busy count", n, 11);
    quiet();
    rst = 1;
    tick("cnt_rst");
    rst = 0;
    load_use();
    repeat (4) tick("cnt_lu");
    quiet();
    D_md_use = 1; E_md_start = 1;
    for (int i = 0; i < 8; i++) begin
      tick("cnt_mult");
      E_md_start = 0;
    end
    quiet();
    tick("cnt_read");
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cycles total", s_sc, 32'd10);
`else
    chk("stall_cycles total", s_sc, 32'd0);
`endif
    rst = 1;
    tick("cnt_clr");
    rst = 0;
    tick("cnt_clr_read");
    chk("stall_cycles cleared", s_sc, 32'd0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      D_rs = 5'($urandom_range(0, 7)); D_rt = 5'($urandom_range(0, 7));
      E_wa = 5'($urandom_range(0, 7)); M_wa = 5'($urandom_range(0, 7));
      D_tuse_rs = 2'($urandom_range(0, 3)); D_tuse_rt = 2'($urandom_range(0, 3));
      E_tnew = 2'($urandom_range(0, 2)); M_tnew = 2'($urandom_range(0, 2));
      D_md_use = 1'($urandom_range(0, 1));
      E_md_start = ($urandom_range(0, 5) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      tick("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
